// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register: operation codes and
// the counter-width helper used by the top and the bench.
package shreg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    // True for the four codes that move data and advance the shift counter.
    function automatic logic is_shift(input mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR) ||
               (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

endpackage

// File: rtl/shreg_bit_cell.sv
// One bit of the universal shift register: a flop with a synchronous
// reset value and a next-value mux steered by the operation code.
module shreg_bit_cell
    import shreg_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  mode_e mode,
    input  logic  i_from_lo,
    input  logic  i_from_hi,
    input  logic  i_load,
    input  logic  i_clear,
    output logic  o_q
);

    logic r_q;
    logic w_next;

    // i_from_lo feeds left moves (SHL/ROL), i_from_hi feeds right moves.
    always_comb begin
        w_next = r_q;
        case (mode)
            MODE_SHL, MODE_ROL: w_next = i_from_lo;
            MODE_SHR, MODE_ROR: w_next = i_from_hi;
            MODE_LOAD:          w_next = i_load;
            MODE_CLEAR:         w_next = i_clear;
            default:            w_next = r_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RST_BIT;
        end else if (en) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shift_register_univ.sv
// Parametrised universal shift register: hold, shift, rotate, load and
// clear, with a saturating shift counter and done level for framing.
module shift_register_univ
    import shreg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CW-1:0]    shift_cnt,
    output logic             done
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_from_lo;
    logic [WIDTH-1:0] w_from_hi;
    logic             w_edge_lo;
    logic             w_edge_hi;
    logic [CW-1:0]    r_cnt;

    // Edge cells see either the serial input or the wrapped opposite bit.
    assign w_edge_lo = (mode == MODE_ROL) ? w_q[WIDTH-1] : sin_l;
    assign w_edge_hi = (mode == MODE_ROR) ? w_q[0]       : sin_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lo_edge
            assign w_from_lo[i] = w_edge_lo;
        end else begin : g_lo_mid
            assign w_from_lo[i] = w_q[i-1];
        end

        if (i == WIDTH - 1) begin : g_hi_edge
            assign w_from_hi[i] = w_edge_hi;
        end else begin : g_hi_mid
            assign w_from_hi[i] = w_q[i+1];
        end

        shreg_bit_cell #(
            .RST_BIT (RESET_VAL[i])
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .mode      (mode),
            .i_from_lo (w_from_lo[i]),
            .i_from_hi (w_from_hi[i]),
            .i_load    (d[i]),
            .i_clear   (RESET_VAL[i]),
            .o_q       (w_q[i])
        );
    end

    // Counts moves since the last LOAD/CLEAR; sticks at WIDTH once framed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            if (mode == MODE_LOAD || mode == MODE_CLEAR) begin
                r_cnt <= '0;
            end else if (is_shift(mode) && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign q         = w_q;
    assign sout_l    = w_q[WIDTH-1];
    assign sout_r    = w_q[0];
    assign shift_cnt = r_cnt;
    assign done      = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_shift_register_univ.sv
// Directed self-checking bench for shift_register_univ (8-bit default
// instance plus a 4-bit instance with a non-zero reset value).
module tb_shift_register_univ;
    import shreg_pkg::*;

    logic       clk;
    logic       rst, en, sin_l, sin_r;
    mode_e      mode;
    logic [7:0] d, q;
    logic       sout_l, sout_r, done;
    logic [3:0] shift_cnt;

    logic       rst4, en4, sin_l4, sin_r4;
    mode_e      mode4;
    logic [3:0] d4, q4;
    logic       sout_l4, sout_r4, done4;
    logic [2:0] shift_cnt4;

    int checks = 0;
    int errors = 0;

    shift_register_univ #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_l(sout_l),
        .sout_r(sout_r), .shift_cnt(shift_cnt), .done(done)
    );

    shift_register_univ #(.WIDTH(4), .RESET_VAL(4'h9)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .mode(mode4), .d(d4),
        .sin_l(sin_l4), .sin_r(sin_r4), .q(q4), .sout_l(sout_l4),
        .sout_r(sout_r4), .shift_cnt(shift_cnt4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge and are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = MODE_LOAD; d = 8'hFF;
        step(); step();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q actual=%h expected=%h", q, 8'h00); end
        checks++; if (shift_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt actual=%0d expected=0", shift_cnt); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done actual=%b expected=0", done); end
        rst = 1'b0;
    endtask

    task automatic test_serialise();
        logic [7:0] exp_bits;
        exp_bits = 8'b1010_0101;
        mode = MODE_LOAD; d = 8'hA5; step();
        checks++; if (sout_l !== exp_bits[7]) begin errors++; $display("FAIL ser_bit0 actual=%b expected=%b", sout_l, exp_bits[7]); end
        mode = MODE_SHL; sin_l = 1'b0;
        for (int k = 1; k < 8; k++) begin
            step();
            checks++;
            if (sout_l !== exp_bits[7-k]) begin errors++; $display("FAIL ser_bit%0d actual=%b expected=%b", k, sout_l, exp_bits[7-k]); end
        end
        step();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL ser_q actual=%h expected=00", q); end
        checks++; if (shift_cnt !== 4'd8) begin errors++; $display("FAIL ser_cnt actual=%0d expected=8", shift_cnt); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ser_done actual=%b expected=1", done); end
        step();
        checks++; if (shift_cnt !== 4'd8) begin errors++; $display("FAIL ser_sat actual=%0d expected=8", shift_cnt); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ser_sat_done actual=%b expected=1", done); end
    endtask

    task automatic test_rotate();
        mode = MODE_LOAD; d = 8'h81; step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rot_load_done actual=%b expected=0", done); end
        mode = MODE_ROL; step();
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL rot_rol actual=%h expected=03", q); end
        mode = MODE_ROR; step(); step();
        checks++; if (q !== 8'hC0) begin errors++; $display("FAIL rot_ror actual=%h expected=c0", q); end
        checks++; if (shift_cnt !== 4'd3) begin errors++; $display("FAIL rot_cnt actual=%0d expected=3", shift_cnt); end
        // Reserved code holds both q and the count.
        mode = MODE_RSVD; step();
        checks++; if (q !== 8'hC0) begin errors++; $display("FAIL rsvd_q actual=%h expected=c0", q); end
        checks++; if (shift_cnt !== 4'd3) begin errors++; $display("FAIL rsvd_cnt actual=%0d expected=3", shift_cnt); end
    endtask

    task automatic test_enable();
        mode = MODE_LOAD; d = 8'h3C; step();
        en = 1'b0; mode = MODE_SHR; sin_r = 1'b1;
        repeat (4) step();
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL en_hold_q actual=%h expected=3c", q); end
        checks++; if (shift_cnt !== 4'd0) begin errors++; $display("FAIL en_hold_cnt actual=%0d expected=0", shift_cnt); end
        en = 1'b1; step();
        checks++; if (q !== 8'h9E) begin errors++; $display("FAIL en_shr_q actual=%h expected=9e", q); end
        checks++; if (shift_cnt !== 4'd1) begin errors++; $display("FAIL en_shr_cnt actual=%0d expected=1", shift_cnt); end
        sin_r = 1'b0;
    endtask

    task automatic test_mid_events();
        mode = MODE_LOAD; d = 8'h5A; step();
        mode = MODE_SHR; sin_r = 1'b0; repeat (3) step();
        checks++; if (q !== 8'h0B) begin errors++; $display("FAIL mid_shr_q actual=%h expected=0b", q); end
        checks++; if (sout_r !== 1'b1) begin errors++; $display("FAIL mid_sout_r actual=%b expected=1", sout_r); end
        mode = MODE_CLEAR; step();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_clr_q actual=%h expected=00", q); end
        checks++; if (shift_cnt !== 4'd0) begin errors++; $display("FAIL mid_clr_cnt actual=%0d expected=0", shift_cnt); end
        mode = MODE_LOAD; d = 8'h5A; step();
        mode = MODE_SHR; repeat (3) step();
        checks++; if (shift_cnt !== 4'd3) begin errors++; $display("FAIL mid_pre_rst_cnt actual=%0d expected=3", shift_cnt); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_rst_q actual=%h expected=00", q); end
        checks++; if (shift_cnt !== 4'd0) begin errors++; $display("FAIL mid_rst_cnt actual=%0d expected=0", shift_cnt); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done actual=%b expected=0", done); end
    endtask

    task automatic test_width4();
        rst4 = 1'b1; en4 = 1'b1; mode4 = MODE_LOAD; d4 = 4'hF; sin_l4 = 1'b0; sin_r4 = 1'b0;
        step(); rst4 = 1'b0;
        checks++; if (q4 !== 4'h9) begin errors++; $display("FAIL w4_reset_q actual=%h expected=9", q4); end
        mode4 = MODE_SHL; repeat (3) step();
        checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL w4_done_early actual=%b expected=0", done4); end
        step();
        checks++; if (q4 !== 4'h0) begin errors++; $display("FAIL w4_shl_q actual=%h expected=0", q4); end
        checks++; if (shift_cnt4 !== 3'd4) begin errors++; $display("FAIL w4_cnt actual=%0d expected=4", shift_cnt4); end
        checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL w4_done actual=%b expected=1", done4); end
        mode4 = MODE_LOAD; d4 = 4'h6; step();
        mode4 = MODE_RSVD; step(); step();
        checks++; if (q4 !== 4'h6) begin errors++; $display("FAIL w4_rsvd_q actual=%h expected=6", q4); end
        checks++; if (shift_cnt4 !== 3'd0) begin errors++; $display("FAIL w4_rsvd_cnt actual=%0d expected=0", shift_cnt4); end
        mode4 = MODE_CLEAR; step();
        checks++; if (q4 !== 4'h9) begin errors++; $display("FAIL w4_clear_q actual=%h expected=9", q4); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = MODE_HOLD; d = '0; sin_l = 1'b0; sin_r = 1'b0;
        rst4 = 1'b1; en4 = 1'b0; mode4 = MODE_HOLD; d4 = '0; sin_l4 = 1'b0; sin_r4 = 1'b0;
        #1;
        test_reset();
        test_serialise();
        test_rotate();
        test_enable();
        test_mid_events();
        test_width4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
